// File: rtl/term_pkg.sv
// Shared terminal definitions: default clocking, UART bit timing helper, TX FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package term_pkg;

  localparam int unsigned DEFAULT_CLK_HZ = 100_000_000;
  localparam int unsigned DEFAULT_BAUD   = 115_200;

  // Serialiser states; the line level for each state is registered one cycle later.
  typedef enum logic [1:0] {
    UTX_IDLE  = 2'd0,
    UTX_START = 2'd1,
    UTX_DATA  = 2'd2,
    UTX_STOP  = 2'd3
  } uart_tx_state_t;

  // Clock cycles per UART bit, rounded to nearest.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is visible combinationally.
// Latency: a pushed word is poppable the cycle after the push edge.
// Backpressure: push while full and pop while empty are ignored; full/empty/count are registered.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
// Latency: push at edge E into idle/empty -> pop at E+1 -> start bit on the line after E+2.
// Backpressure: tx_ready = FIFO not full (registered); frames from a non-empty FIFO run back-to-back.
module uart_tx_fifo
  import term_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
  parameter int unsigned BAUD   = DEFAULT_BAUD,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                   clk100,
  input  logic                   rst_n,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   uart_tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned BW           = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

  uart_tx_state_t state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;

  logic           fifo_push, fifo_pop;
  logic           fifo_full, fifo_empty;
  logic [7:0]     fifo_head;
  logic           baud_last;

  assign fifo_push = tx_valid && tx_ready;
  assign tx_ready  = !fifo_full;
  assign baud_last = (baud_q == BAUD_LAST);
  assign uart_tx   = tx_q;
  assign busy      = (state_q != UTX_IDLE) || (fifo_count != '0);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk100),
    .rst_ni     (rst_n),
    .push_i     (fifo_push),
    .push_dat_i (tx_data),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // Serialiser next-state: bit timing, shift register, and FIFO pop at frame boundaries.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_last ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      UTX_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = UTX_START;
        end
      end
      UTX_START: begin
        if (baud_last) begin
          bit_d   = 3'd0;
          state_d = UTX_DATA;
        end
      end
      UTX_DATA: begin
        if (baud_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = UTX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      UTX_STOP: begin
        if (baud_last) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            state_d  = UTX_START;
          end else begin
            state_d  = UTX_IDLE;
          end
        end
      end
      default: state_d = UTX_IDLE;
    endcase
  end

  // Line level follows the current state, registered so the pin never glitches.
  always_comb begin
    case (state_q)
      UTX_START: tx_d = 1'b0;
      UTX_DATA:  tx_d = shift_q[0];
      default:   tx_d = 1'b1;
    endcase
  end

  // Serialiser registers; reset drops any frame in flight and idles the line high.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UTX_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter: the transmit-side counterpart of the terminal's UART receive path. Bytes are pushed by a valid/ready handshake into a small FIFO and serialised onto `uart_tx` at a fixed baud rate, LSB first. It sits between the keyboard/terminal logic and the `uart_tx` pin, so producers can emit short bursts without stalling on bit timing.

## Interface
- `CLK_HZ`, 100000000, clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s; `CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD` (868 at defaults), must be ≥ 2
- `DEPTH`, 16, FIFO depth in bytes, power of two, ≥ 2
- `clk100  input  1  system clock; all logic on its rising edge`
- `rst_n  input  1  asynchronous, active-low reset`
- `tx_data  input  8  byte to send`
- `tx_valid  input  1  producer offers `tx_data``
- `tx_ready  output  1  FIFO can accept; high when count < DEPTH`
- `uart_tx  output  1  serial line, idle high`
- `busy  output  1  high while a frame is on the line or FIFO is non-empty`
- `fifo_count  output  $clog2(DEPTH)+1  bytes held in FIFO (not including the frame in flight)`

## Operation
- Push: byte accepted on a rising edge where `tx_valid && tx_ready`. `tx_data` is sampled only then; `tx_valid` while `tx_ready` is low is ignored (no drop, no error; producer holds).
- Serialiser FSM, states IDLE, START, DATA, STOP:
  - IDLE: `uart_tx`=1. If FIFO non-empty: pop head into shift register, go START.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles, go DATA with bit index 0.
  - DATA: `uart_tx`=shift[0] for CLKS_PER_BIT cycles, shift right; after bit index 7 go STOP.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles. At its last cycle: if FIFO non-empty, pop and go START directly (no idle gap); else go IDLE.
- Baud counter: width `$clog2(CLKS_PER_BIT)`, counts 0..CLKS_PER_BIT-1, reloads on each bit boundary; reset to 0 on every state entry.
- `uart_tx` is a registered output (glitch-free).
- FIFO pointers `$clog2(DEPTH)` bits, wrap modulo DEPTH; count increments on push-only, decrements on pop-only, unchanged on simultaneous push+pop.
- Simultaneous push and pop when full: `tx_ready` is low (from registered count), push rejected; pop proceeds; `tx_ready` rises next cycle.
- Simultaneous push into empty FIFO while FSM in IDLE: byte is not bypassed; it is popped the following cycle.
- `busy` = (state != IDLE) || (fifo_count != 0).

## Timing
- Reset (async assert, sync-to-edge release): `uart_tx`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0, state IDLE, pointers 0. Reset mid-frame: line returns high immediately, frame and FIFO contents discarded.
- Latency: byte pushed at edge E into empty FIFO with FSM idle → popped at edge E+1 → `uart_tx` low after edge E+2.
- Frame length exactly 10 × CLKS_PER_BIT cycles; back-to-back frames from a non-empty FIFO are contiguous (stop bit of n followed immediately by start of n+1).
- `tx_ready`, `fifo_count` update the cycle after the push/pop edge.

## Structure
- Shared package `term_pkg`: default `CLK_HZ`, default `BAUD`, function computing CLKS_PER_BIT, FSM state enum `uart_tx_state_t`.
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH; push/pop, full/empty, count), reusable for the receive side later.
- Serialiser FSM, baud counter, shift register live in `uart_tx_fifo`.

## Test plan
- Use CLK_HZ=1000, BAUD=100 (CLKS_PER_BIT=10), DEPTH=4 unless stated.
- Reset: hold `rst_n`=0 5 cycles → `uart_tx`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0.
- Single byte 0x55 pushed at edge E → `uart_tx` low from E+2 for 10 cycles, then bits 1,0,1,0,1,0,1,0 each 10 cycles, stop high 10 cycles; `busy` low after frame.
- Burst 0x41,0x42,0x43 on consecutive cycles → three contiguous 100-cycle frames, no idle gap; decoded bytes 0x41,0x42,0x43 in order.
- Fill: push 6 bytes while first frame in flight → `tx_ready` drops when `fifo_count`=4; producer holds; all 6 bytes emerge in order, none lost or duplicated.
- Reset mid-frame: assert `rst_n`=0 during DATA bit 3 of 0xA5 with 2 bytes queued → `uart_tx`=1 asynchronously, `fifo_count`=0; after release line stays idle.
- Defaults (CLK_HZ=100000000, BAUD=115200): 0x00 → start+8 data bits low for 9×868 cycles, then stop high 868 cycles.
